// File: rtl/seq_normalizer.sv
// Multi-cycle leading-bit normalizer for CLZ/CLO: shifts the operand left one bit
// per cycle until the MSB differs from the fill bit, then reports count and result.
module seq_normalizer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             negative_q, negative_d;
   logic             finish;

   // Stop once the MSB no longer matches the fill bit, or the whole word was fill.
   assign finish = (shreg_q[WIDTH-1] != mode_q) || (cnt_q == CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE:  state_d = start ? ST_SHIFT : ST_IDLE;
         ST_SHIFT: state_d = finish ? ST_DONE : ST_SHIFT;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // busy and done are registered views of the state being entered.
   always_comb begin
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   always_comb begin
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      count_d    = count_q;
      result_d   = result_q;
      zero_d     = zero_q;
      negative_d = negative_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shreg_d = data_in;
               mode_d  = mode;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (finish) begin
               count_d    = cnt_q;
               result_d   = shreg_q;
               zero_d     = (shreg_q == '0);
               negative_d = shreg_q[WIDTH-1];
            end else begin
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // The working registers need no reset; the visible results do.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      if (rst) begin
         count_q    <= '0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         negative_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         negative_q <= negative_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign count    = count_q;
   assign result   = result_q;
   assign zero     = zero_q;
   assign negative = negative_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed bench for seq_normalizer with hand-computed counts, results and latencies.
module tb_seq_normalizer;
   localparam int WIDTH = 32;
   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] data_in;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             negative;

   int errors = 0;
   int checks = 0;

   seq_normalizer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
      .busy(busy), .done(done), .count(count), .result(result),
      .zero(zero), .negative(negative)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Edge 0 is the start edge; done must appear after edge n+1, busy after edges 0..n.
   task automatic run_job(input string tag, input logic [WIDTH-1:0] d, input logic m,
                          input int exp_cnt, input logic [WIDTH-1:0] exp_res,
                          input logic exp_z, input logic exp_n);
      int lat;
      int busy_cyc;
      start   = 1'b1;
      data_in = d;
      mode    = m;
      tick();
      start   = 1'b0;
      data_in = ~d;
      mode    = ~m;
      lat      = 0;
      busy_cyc = busy ? 1 : 0;
      while (!done && lat < WIDTH + 5) begin
         tick();
         lat++;
         if (busy) busy_cyc++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_cnt + 1));
      chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_cnt + 1));
      chk({tag, "_count"}, 64'(count), 64'(exp_cnt));
      chk({tag, "_result"}, 64'(result), 64'(exp_res));
      chk({tag, "_zero"}, 64'(zero), 64'(exp_z));
      chk({tag, "_negative"}, 64'(negative), 64'(exp_n));
      tick();
      chk({tag, "_done_pulse"}, 64'(done), 64'(0));
      chk({tag, "_count_hold"}, 64'(count), 64'(exp_cnt));
   endtask

   initial begin
      int lat;
      rst     = 1'b1;
      start   = 1'b1;
      mode    = 1'b0;
      data_in = 32'h8000_0000;
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_flags", 64'({zero, negative}), 64'(0));
      rst   = 1'b0;
      start = 1'b0;
      tick();
      chk("rst_start_lost", 64'(busy), 64'(0));

      run_job("clz_bit16", 32'h0001_0000, 1'b0, 15, 32'h8000_0000, 1'b0, 1'b1);
      run_job("clz_msb",   32'h8000_0000, 1'b0, 0,  32'h8000_0000, 1'b0, 1'b1);
      run_job("clz_zero",  32'h0000_0000, 1'b0, 32, 32'h0000_0000, 1'b1, 1'b0);
      run_job("clo_fff",   32'hFFF0_1234, 1'b1, 12, 32'h0123_4000, 1'b0, 1'b0);
      run_job("clo_ones",  32'hFFFF_FFFF, 1'b1, 32, 32'h0000_0000, 1'b1, 1'b0);

      // Start during SHIFT must be ignored.
      start = 1'b1; data_in = 32'h0000_0F00; mode = 1'b0;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      start = 1'b1; data_in = 32'h0000_0001; mode = 1'b1;
      tick();
      start = 1'b0;
      lat = 4;
      while (!done && lat < WIDTH + 5) begin
         tick();
         lat++;
      end
      chk("ign_lat", 64'(lat), 64'(21));
      chk("ign_count", 64'(count), 64'(20));
      chk("ign_result", 64'(result), 64'hF000_0000);
      tick();

      // Start held through DONE is taken only in the following IDLE cycle.
      start = 1'b1; data_in = 32'h8000_0000; mode = 1'b0;
      tick();
      data_in = 32'h0001_0000;
      chk("hold_busy_e0", 64'(busy), 64'(1));
      tick();
      chk("hold_done_e1", 64'(done), 64'(1));
      chk("hold_count_e1", 64'(count), 64'(0));
      tick();
      chk("hold_busy_e2", 64'(busy), 64'(0));
      chk("hold_done_e2", 64'(done), 64'(0));
      tick();
      chk("hold_busy_e3", 64'(busy), 64'(1));
      start = 1'b0;
      lat = 0;
      while (!done && lat < WIDTH + 5) begin
         tick();
         lat++;
      end
      chk("hold_lat", 64'(lat), 64'(16));
      chk("hold_count", 64'(count), 64'(15));
      chk("hold_result", 64'(result), 64'h8000_0000);
      tick();

      // Reset at edge 5 aborts the job.
      start = 1'b1; data_in = 32'h0000_0001; mode = 1'b0;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_count", 64'(count), 64'(0));
      chk("abort_result", 64'(result), 64'(0));
      chk("abort_flags", 64'({zero, negative}), 64'(0));
      rst = 1'b0;
      lat = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         tick();
         if (done) lat++;
      end
      chk("abort_no_done", 64'(lat), 64'(0));
      run_job("after_rst", 32'h4000_0000, 1'b0, 1, 32'h8000_0000, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
